// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. It processes one bit per clock, LSB first, through a single full-adder cell.
// Defining SERIAL_ADDER_OVF_EN adds a registered signed-overflow output, ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic bit_sum;
  logic bit_carry;
  logic last_bit;

  // Full-adder cell. It works on the current LSB of the two operand shift registers.
  assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is computed as a + ~b + 1. cin is irrelevant in that mode.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {bit_sum, acc[WIDTH-1:1]};
          carry <= bit_carry;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // The visible result changes only here, so sum and cout hold steady during RUN.
            state <= IDLE;
            sum   <= {bit_sum, acc[WIDTH-1:1]};
            cout  <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ bit_carry;
`endif
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). It checks the DUT against an arithmetic reference model.
// It also checks the ovf output when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];  // {ovf, cout, sum}

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain two's-complement arithmetic on a (W+1)-bit sum
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
    ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {ov, full};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W+1:0] observed();
`ifdef SERIAL_ADDER_OVF_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  // Driver: present the operands with start for one rising edge, then return at the following falling edge
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: sample at each falling edge until done is seen or the cycle budget expires
  task automatic watch_run(output int lat, output int busy_n, output int sum_chg);
    logic [W-1:0] s0;
    s0 = sum; lat = 0; busy_n = 0; sum_chg = 0;
    while (!done && lat < 4 * W) begin
      if (busy) busy_n++;
      if (sum !== s0) sum_chg++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL reset_result: got %b/%h want 0/00", cout, sum); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({busy, done, cout, sum} !== 11'h000) begin
      errors++; $display("FAIL idle_hold: busy=%b done=%b cout=%b sum=%h want all zero", busy, done, cout, sum);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W+1:0] exp;  // {ovf, cout, sum}
  } vec_t;

  task automatic test_directed();
    vec_t vecs[8];
    int lat, busy_n, sum_chg;
    logic [W+1:0] got;
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 10'b0_1_00000000};
    vecs[1] = '{8'h35, 8'h0A, 1'b0, 1'b1, 10'b0_0_01000000};
    vecs[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 10'b0_0_11110000};
    vecs[3] = '{8'h20, 8'h10, 1'b1, 1'b0, 10'b0_1_00010000};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 10'b1_0_10000000};
    vecs[5] = '{8'h20, 8'h10, 1'b1, 1'b1, 10'b0_1_00010000};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 10'b1_1_01111111};
    vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 10'b0_1_11111111};
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      watch_run(lat, busy_n, sum_chg);
      got = observed();
      checks++; if (lat != W) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
      checks++; if (busy_n != W) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_n, W); end
      checks++; if (sum_chg != 0) begin errors++; $display("FAIL dir%0d_sum_hold: sum changed %0d times during run, want 0", i, sum_chg); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (got !== vecs[i].exp) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, got, vecs[i].exp); end
`else
      checks++; if (got[W:0] !== vecs[i].exp[W:0]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, got[W:0], vecs[i].exp[W:0]); end
`endif
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: done still %b one cycle later, want 0", i, done); end
    end
  endtask

  task automatic test_random();
    int lat, busy_n, sum_chg;
    logic [W-1:0] ra, rb;
    logic rs, rc;
    logic [W+1:0] exp, got;
    for (int n = 0; n < 40; n++) begin
      ra = pick_operand(); rb = pick_operand();
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rs, rc));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(ra, rb, rs, rc);
      watch_run(lat, busy_n, sum_chg);
      exp = exp_q.pop_front();
      got = observed();
      checks++; if (lat != W || busy_n != W || sum_chg != 0) begin
        errors++; $display("FAIL rnd%0d_timing: lat=%0d busy=%0d sum_changes=%0d want %0d/%0d/0", n, lat, busy_n, sum_chg, W, W);
      end
`ifndef SERIAL_ADDER_OVF_EN
      exp[W+1] = 1'b0;
`endif
      checks++; if (got !== exp) begin
        errors++; $display("FAIL rnd%0d_result: a=%h b=%h sub=%b cin=%b got %h want %h", n, ra, rb, rs, rc, got, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, busy_n, extra;
    logic [W+1:0] exp, got;
    exp = model(8'h5A, 8'h3C, 1'b0, 1'b1);
    launch(8'h5A, 8'h3C, 1'b0, 1'b1);
    lat = 0; busy_n = 0;
    while (!done && lat < 4 * W) begin
      if (busy) busy_n++;
      if (lat == 3) begin
        a = 8'hC3; b = 8'h99; sub = 1'b1; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    got = observed();
`ifndef SERIAL_ADDER_OVF_EN
    exp[W+1] = 1'b0;
`endif
    checks++; if (lat != W || busy_n != W) begin errors++; $display("FAIL ignore_timing: lat=%0d busy=%0d want %0d/%0d", lat, busy_n, W, W); end
    checks++; if (got !== exp) begin errors++; $display("FAIL ignore_result: got %h want %h", got, exp); end
    extra = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_not_queued: %0d busy/done cycles after result, want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, sum_chg;
    logic [W+1:0] exp, got;
    exp_q.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
    exp_q.push_back(model(8'h05, 8'h09, 1'b1, 1'b0));
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    watch_run(lat, busy_n, sum_chg);
    exp = exp_q.pop_front(); got = observed();
`ifndef SERIAL_ADDER_OVF_EN
    exp[W+1] = 1'b0;
`endif
    checks++; if (lat != W || got !== exp) begin errors++; $display("FAIL b2b_first: lat=%0d got %h want %0d/%h", lat, got, W, exp); end
    // We are in the done cycle: request the second operation now.
    a = 8'h05; b = 8'h09; sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", busy, done); end
    watch_run(lat, busy_n, sum_chg);
    exp = exp_q.pop_front(); got = observed();
`ifndef SERIAL_ADDER_OVF_EN
    exp[W+1] = 1'b0;
`endif
    checks++; if (lat != W || busy_n != W) begin errors++; $display("FAIL b2b_second_timing: lat=%0d busy=%0d want %0d/%0d", lat, busy_n, W, W); end
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_second_result: got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, sum_chg, pulses;
    logic [W+1:0] exp, got;
    launch(8'h77, 8'h66, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: busy=%b done=%b want 0/0", busy, done); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL rstmid_result: cout=%b sum=%h want 0/00", cout, sum); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done: %0d busy/done cycles after abort, want 0", pulses); end
    exp = model(8'hA5, 8'h5B, 1'b1, 1'b1);
    launch(8'hA5, 8'h5B, 1'b1, 1'b1);
    watch_run(lat, busy_n, sum_chg);
    got = observed();
`ifndef SERIAL_ADDER_OVF_EN
    exp[W+1] = 1'b0;
`endif
    checks++; if (lat != W || got !== exp) begin errors++; $display("FAIL rstmid_after: lat=%0d got %h want %0d/%h", lat, got, W, exp); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1, mode select: 0 = add, 1 = subtract; captured with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands; captured with start.
REQ-007 The block SHALL have port cin, input, 1, carry-in for add mode; captured with start; ignored when sub=1.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum, output, WIDTH, registered result.
REQ-011 The block SHALL have port cout, output, 1, registered carry-out; in subtract mode 1 = no borrow.

Function
REQ-012 The block SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-013 In IDLE, start=1 at a clock edge SHALL capture a, b, sub and cin, clear the bit counter, and enter RUN.
REQ-014 In subtract mode, the captured b SHALL be inverted and the initial carry SHALL be 1, giving a + ~b + 1; otherwise the initial carry SHALL be cin.
REQ-015 Each RUN edge SHALL process one bit, LSB first, using a 1-bit full-adder cell and a carry flop: sum bit = a^b^c, next c = majority(a,b,c).
REQ-016 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the block SHALL return to IDLE, load sum and cout, and assert done for one cycle.
REQ-017 Latency SHALL be WIDTH cycles from the start-sampling edge to done high; busy SHALL be high for exactly WIDTH cycles.
REQ-018 sum and cout SHALL hold the previous result throughout RUN and SHALL change only on the completion edge.
REQ-019 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and operand registers, independent of clk.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Configuration
REQ-024 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf (1 bit, reset 0): the signed overflow, equal to the carry into the MSB XOR the carry out of the MSB, updated with sum.
REQ-025 With SERIAL_ADDER_OVF_EN undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-026 Hold rst_n=0 -> busy=0, done=0, sum=8'h00, cout=0; release, no start -> outputs unchanged.
REQ-027 Add a=8'hFF, b=8'h01, cin=0 -> busy high 8 cycles, done after 8 cycles, sum=8'h00, cout=1; then a=8'h35, b=8'h0A, cin=1 -> sum=8'h40, cout=0.
REQ-028 Sub a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0; sub a=8'h20, b=8'h10 -> sum=8'h10, cout=1.
REQ-029 With OVF_EN: add a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
REQ-030 Start pulsed 3 cycles into RUN with different operands -> ignored, first result delivered unchanged; start held in the done cycle -> second operation starts immediately, done again 8 cycles later.
REQ-031 rst_n pulsed low 3 cycles after start -> busy=0 and sum=8'h00 at once, no done pulse; a following start yields a correct result.
